// File: rtl/regfile_wb_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | Module  : regfile_wb_arbiter_pkg                                         |
// | Brief   : Shared widths and types for the register-bank writeback path.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package regfile_wb_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 1 << ADDR_W;
  localparam int CNT_W  = 16;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | Module  : regfile_wb_arbiter_if                                          |
// | Brief   : Writeback request handshakes and bank write-port bundle.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              hold;
  logic              regw_en;
  logic [ADDR_W-1:0] inrw;
  logic [DATA_W-1:0] regw_data;
  logic [NREG-1:0]   pend_mask;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output a_valid, a_addr, a_data, m_valid, m_addr, m_data, hold,
    input  a_ready, m_ready, regw_en, inrw, regw_data, pend_mask, conflict_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, m_valid, m_addr, m_data, hold,
    output a_ready, m_ready, regw_en, inrw, regw_data, pend_mask, conflict_cnt
  );

endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// +--------------------------------------------------------------------------+
// | Module  : rr_arb2                                                        |
// | Brief   : Two-way round-robin arbiter; pointer moves on contention only. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [1:0] req,
  input  wire logic       stall,
  output logic      [1:0] gnt
);

  src_t       r_rr_ptr;
  logic [1:0] w_gnt;
  logic       w_contended;

  assign w_contended = &req;

  always_comb begin
    w_gnt = 2'b00;
    if (!stall) begin
      if (w_contended) begin
        w_gnt = (r_rr_ptr == SRC_ALU) ? 2'b01 : 2'b10;
      end else begin
        w_gnt = req;
      end
    end
  end

  assign gnt = w_gnt;

  // The pointer swings to the loser so it wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= SRC_ALU;
    end else if (!stall && w_contended) begin
      r_rr_ptr <= w_gnt[0] ? SRC_MEM : SRC_ALU;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module  : regfile_wb_arbiter                                             |
// | Brief   : Arbitrates ALU/load writebacks into a 1-entry bank write stage.|
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst_n,
  regfile_wb_arbiter_if.slave bus
);

  wb_req_t          w_a_req;
  wb_req_t          w_m_req;
  wb_req_t          w_win;
  wb_req_t          r_stage;
  logic             w_stage_free;
  logic             w_stall;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic [NREG-1:0]  w_pend_mask;
  logic [CNT_W-1:0] r_conflict_cnt;

  assign w_a_req = '{valid: bus.a_valid, addr: bus.a_addr, data: bus.a_data};
  assign w_m_req = '{valid: bus.m_valid, addr: bus.m_addr, data: bus.m_data};

  assign w_stage_free = !r_stage.valid || !bus.hold;
  assign w_stall      = !w_stage_free;
  assign w_req        = {bus.m_valid, bus.a_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_req),
    .stall (w_stall),
    .gnt   (w_gnt)
  );

  assign bus.a_ready = w_gnt[0];
  assign bus.m_ready = w_gnt[1];

  // A grant implies the winner's valid is set, so the whole request is captured.
  assign w_win = w_gnt[1] ? w_m_req : w_a_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (|w_gnt) begin
      r_stage <= w_win;
    end else if (w_stage_free) begin
      r_stage.valid <= 1'b0;
    end
  end

  assign bus.regw_en   = r_stage.valid && !bus.hold;
  assign bus.inrw      = r_stage.addr;
  assign bus.regw_data = r_stage.data;

  for (genvar i = 0; i < NREG; i++) begin : g_pend_mask
    assign w_pend_mask[i] = r_stage.valid && (r_stage.addr == ADDR_W'(i));
  end

  assign bus.pend_mask = w_pend_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (bus.a_valid && bus.m_valid && !(&r_conflict_cnt)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign bus.conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_regfile_wb_arbiter                                          |
// | Brief   : Directed and random checks of regfile_wb_arbiter vs a model.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] dut_bank [NREG];
  logic [DATA_W-1:0] mdl_bank [NREG];

  // Reference: preferred source on a tie, one pending write, saturating count.
  bit                m_pref_mem;
  bit                m_sv;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int unsigned       m_cnt;
  bit                last_ga;
  bit                last_gm;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pref_mem = 1'b0;
    m_sv       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    m_cnt      = 0;
  endtask

  task automatic drive_idle();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_data = '0;
    bus.hold    = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_regw_en"}, 32'(bus.regw_en), 32'd0);
    check_eq({tag, "_inrw"},    32'(bus.inrw), 32'd0);
    check_eq({tag, "_data"},    32'(bus.regw_data), 32'd0);
    check_eq({tag, "_pend"},    32'(bus.pend_mask), 32'd0);
    check_eq({tag, "_cnt"},     32'(bus.conflict_cnt), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                      input bit h);
    bit              en, free, both, ga, gm;
    logic [NREG-1:0] pm;
    @(negedge clk);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.m_valid = mv; bus.m_addr = ma; bus.m_data = md;
    bus.hold    = h;
    #1;
    en   = m_sv && !h;
    free = !m_sv || !h;
    both = av && mv;
    ga   = 1'b0;
    gm   = 1'b0;
    if (free) begin
      if (both) begin
        ga = !m_pref_mem;
        gm = m_pref_mem;
      end else begin
        ga = av;
        gm = mv;
      end
    end
    pm = m_sv ? (NREG'(1) << m_addr) : '0;
    check_eq("a_ready",   32'(bus.a_ready), 32'(ga));
    check_eq("m_ready",   32'(bus.m_ready), 32'(gm));
    check_eq("regw_en",   32'(bus.regw_en), 32'(en));
    check_eq("inrw",      32'(bus.inrw), 32'(m_addr));
    check_eq("regw_data", 32'(bus.regw_data), 32'(m_data));
    check_eq("pend_mask", 32'(bus.pend_mask), 32'(pm));
    check_eq("cnt",       32'(bus.conflict_cnt), m_cnt);
    if (bus.regw_en) dut_bank[bus.inrw] = bus.regw_data;
    if (en) mdl_bank[m_addr] = m_data;
    if (both && m_cnt < 32'hFFFF) m_cnt++;
    if (both && free) m_pref_mem = ga;
    if (ga) begin
      m_sv = 1'b1; m_addr = aa; m_data = ad;
    end else if (gm) begin
      m_sv = 1'b1; m_addr = ma; m_data = md;
    end else if (free) begin
      m_sv = 1'b0;
    end
    last_ga = ga;
    last_gm = gm;
  endtask

  task automatic idle_step();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  bit                pa_v, pm_v, rh;
  logic [ADDR_W-1:0] pa_a, pm_a;
  logic [DATA_W-1:0] pa_d, pm_d;

  initial begin
    for (int i = 0; i < NREG; i++) begin
      dut_bank[i] = '0;
      mdl_bank[i] = '0;
    end
    drive_idle();
    model_reset();

    // Single ALU write, one-cycle latency
    do_reset();
    step(1'b1, 3'd3, 16'h1234, 1'b0, '0, '0, 1'b0);
    check_eq("t1_a_ready", 32'(bus.a_ready), 32'd1);
    idle_step();
    check_eq("t1_regw_en", 32'(bus.regw_en), 32'd1);
    check_eq("t1_inrw", 32'(bus.inrw), 32'd3);
    check_eq("t1_data", 32'(bus.regw_data), 32'h1234);
    check_eq("t1_pend", 32'(bus.pend_mask), 32'h08);

    // Contended round robin: A,M,A,M
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd1, DATA_W'(16'hA000 + i), 1'b1, 3'd2, DATA_W'(16'hB000 + i), 1'b0);
      check_eq("t2_gnt", 32'({bus.a_ready, bus.m_ready}), (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    idle_step();
    check_eq("t2_cnt", 32'(bus.conflict_cnt), 32'd4);
    check_eq("t2_last_write", 32'(bus.regw_en), 32'd1);
    idle_step();

    // Hold a captured load, then release with ALU waiting
    step(1'b0, '0, '0, 1'b1, 3'd5, 16'hBEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd6, 16'h0606, 1'b0, '0, '0, 1'b1);
      check_eq("t3_hold_en", 32'(bus.regw_en), 32'd0);
      check_eq("t3_hold_pend", 32'(bus.pend_mask), 32'h20);
      check_eq("t3_hold_ready", 32'(bus.a_ready), 32'd0);
    end
    step(1'b1, 3'd6, 16'h0606, 1'b0, '0, '0, 1'b0);
    check_eq("t3_rel_en", 32'(bus.regw_en), 32'd1);
    check_eq("t3_rel_inrw", 32'(bus.inrw), 32'd5);
    check_eq("t3_rel_data", 32'(bus.regw_data), 32'hBEEF);
    check_eq("t3_rel_ready", 32'(bus.a_ready), 32'd1);
    idle_step();
    idle_step();

    // Same-address race: later (M) write lands last
    do_reset();
    step(1'b1, 3'd4, 16'h0001, 1'b1, 3'd4, 16'h0002, 1'b0);
    step(1'b0, '0, '0, 1'b1, 3'd4, 16'h0002, 1'b0);
    idle_step();
    idle_step();
    check_eq("t4_r4", 32'(dut_bank[4]), 32'h0002);

    // Reset drops a captured write
    do_reset();
    dut_bank[7] = 16'h5A5A;
    mdl_bank[7] = 16'h5A5A;
    step(1'b1, 3'd7, 16'h7777, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    drive_idle();
    #1;
    check_eq("t5_pre_en", 32'(bus.regw_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t5");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("t5_r7_kept", 32'(dut_bank[7]), 32'h5A5A);
    step(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b0);
    check_eq("t5_ptr_alu", 32'(bus.a_ready), 32'd1);
    step(1'b0, '0, '0, 1'b1, 3'd2, 16'h2222, 1'b0);
    idle_step();
    idle_step();

    // Counter saturation
    @(negedge clk);
    drive_idle();
    force dut.r_conflict_cnt = 16'hFFFE;
    #1;
    release dut.r_conflict_cnt;
    m_cnt = 32'hFFFE;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd0, DATA_W'(i), 1'b1, 3'd1, DATA_W'(i + 8), 1'b0);
    end
    step(1'b0, '0, '0, 1'b1, 3'd1, 16'h0008, 1'b0);
    check_eq("t6_sat", 32'(bus.conflict_cnt), 32'hFFFF);
    idle_step();
    idle_step();

    // Random traffic with protocol-respecting sources
    pa_v = 1'b0;
    pm_v = 1'b0;
    pa_a = '0; pa_d = '0; pm_a = '0; pm_d = '0;
    last_ga = 1'b0;
    last_gm = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!pa_v || last_ga) begin
        pa_v = ($urandom_range(0, 3) != 0);
        pa_a = ADDR_W'($urandom_range(0, NREG - 1));
        pa_d = DATA_W'($urandom);
      end
      if (!pm_v || last_gm) begin
        pm_v = ($urandom_range(0, 2) != 0);
        pm_a = ADDR_W'($urandom_range(0, NREG - 1));
        pm_d = DATA_W'($urandom);
      end
      rh = ($urandom_range(0, 3) == 0);
      step(pa_v, pa_a, pa_d, pm_v, pm_a, pm_d, rh);
    end
    idle_step();
    idle_step();
    for (int i = 0; i < NREG; i++) begin
      check_eq("bank", 32'(dut_bank[i]), 32'(mdl_bank[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
